imem_word_reader: RTL and testbench

Reads a range of the byte-addressed, little-endian instruction memory back out as 32-bit words. It is the read-side counterpart to the word-to-4-byte split used when the instruction memory is loaded.
- Sits between the MIPS instruction memory's secondary byte read port and a debug/verification consumer, which receives a valid/ready word stream.
- Used for program readback and checksum after load, before the core is released.

---
 rtl/imem_word_reader_pkg.sv | 22 ++
 rtl/imem_word_reader_if.sv | 30 +++
 rtl/imem_word_reader_le_word_assembler.sv | 29 ++
 rtl/imem_word_reader.sv | 111 +++++++++++
 tb/tb_imem_word_reader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_word_reader_pkg.sv
// Shared types and helpers for the instruction-memory word readback path.
package imem_word_reader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_PRESENT,
    ST_DONE
  } state_e;

  // Little-endian lane to bit offset: byte k of a word lives at bits [8k+7:8k].
  function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/imem_word_reader_if.sv
// Control, byte-memory and word-stream signals of the word reader.
interface imem_word_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, word_count, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_data, out_addr, busy, done
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, busy, done
  );

endinterface

// File: rtl/imem_word_reader_le_word_assembler.sv
// Collects four returned bytes into a little-endian 32-bit word.
module le_word_assembler
  import imem_word_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] lane;

  // Clear at the start of each word, then insert bytes lane 0..3 in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      word <= '0;
    end else if (clr) begin
      lane <= '0;
      word <= '0;
    end else if (cap) begin
      word[lane_lsb(lane) +: BYTE_W] <= byte_in;
      lane <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/imem_word_reader.sv
// Reads a byte-addressed instruction memory range back as a 32-bit word stream.
module imem_word_reader
  import imem_word_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_word_reader_if.master  bus
);

  state_e            state;
  logic [ADDR_W-1:0] cur;
  logic [CNT_W-1:0]  remaining;
  logic [LANE_W-1:0] issue_cnt;
  logic              rd_pend;
  logic              clr_c;
  logic [WORD_W-1:0] asm_word;

  // A new word begins whenever the FSM heads into ISSUE.
  assign clr_c = ((state == ST_IDLE) && bus.start && (bus.word_count != '0)) ||
                 ((state == ST_PRESENT) && bus.out_ready);

  // Controller: byte issue, drain of the last read, word handshake and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cur           <= '0;
      remaining     <= '0;
      issue_cnt     <= '0;
      rd_pend       <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      rd_pend  <= bus.mem_rd_en;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.word_count != '0) begin
              cur           <= bus.base_addr;
              remaining     <= bus.word_count;
              issue_cnt     <= '0;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= bus.base_addr;
              bus.busy      <= 1'b1;
              state         <= ST_ISSUE;
            end else begin
              bus.done <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_cnt == LANE_W'(BYTES_PER_WORD - 1)) begin
            bus.mem_rd_en <= 1'b0;
            state         <= ST_DRAIN;
          end else begin
            issue_cnt    <= issue_cnt + LANE_W'(1);
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          bus.out_valid <= 1'b1;
          bus.out_addr  <= cur;
          state         <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            cur           <= cur + ADDR_W'(BYTES_PER_WORD);
            remaining     <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              issue_cnt     <= '0;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= cur + ADDR_W'(BYTES_PER_WORD);
              state         <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  le_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .cap     (rd_pend),
    .byte_in (bus.mem_rdata),
    .word    (asm_word)
  );

  assign bus.out_data = asm_word;

endmodule

// File: tb/tb_imem_word_reader.sv
// Directed scoreboard bench for imem_word_reader.
module tb_imem_word_reader;
  import imem_word_reader_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_word_reader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  imem_word_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [7:0] mem [256];

  // One-cycle synchronous byte memory.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[7:0]];

  logic [ADDR_W-1:0]    q_addr [$];
  logic [ADDR_W+31:0]   q_word [$];

  int check_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int cyc = 0, cyc_start = 0;
  int rd_cnt, first_rd, first_valid, last_done, words_rx, done_cnt = 0;
  bit busy_seen;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data, last_rx_data;
  logic [ADDR_W-1:0] prev_addr, last_rx_addr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a);
    return {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[8'(a)]};
  endfunction

  task automatic push_burst(input logic [ADDR_W-1:0] base, input int count);
    for (int w = 0; w < count; w++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(4 * w);
      q_word.push_back({a, exp_word(a)});
      for (int k = 0; k < 4; k++) q_addr.push_back(a + ADDR_W'(k));
    end
  endtask

  // Observes the values the coming rising edge will see.
  task automatic monitor();
    logic [ADDR_W+31:0] e;
    if (!rst_n) return;
    if (bus.mem_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      chk("rd_expected", 128'(q_addr.size() != 0), 128'(1));
      if (q_addr.size() != 0) chk("mem_addr", 128'(bus.mem_addr), 128'(q_addr.pop_front()));
    end
    if (bus.out_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (prev_valid && !prev_ready) begin
        chk("hold_data", 128'(bus.out_data), 128'(prev_data));
        chk("hold_addr", 128'(bus.out_addr), 128'(prev_addr));
      end
      if (bus.out_ready) begin
        words_rx++;
        last_rx_data = bus.out_data;
        last_rx_addr = bus.out_addr;
        chk("word_expected", 128'(q_word.size() != 0), 128'(1));
        if (q_word.size() != 0) begin
          e = q_word.pop_front();
          chk("out_addr", 128'(bus.out_addr), 128'(e[ADDR_W+31:32]));
          chk("out_data", 128'(bus.out_data), 128'(e[31:0]));
        end
      end
    end
    if (bus.done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (bus.busy) busy_seen = 1'b1;
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
    prev_addr  = bus.out_addr;
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_req(input logic [ADDR_W-1:0] base, input int count);
    rd_cnt = 0; first_rd = -1; first_valid = -1; last_done = -1;
    words_rx = 0; busy_seen = 1'b0;
    bus.base_addr  = base;
    bus.word_count = CNT_W'(count);
    bus.start      = 1'b1;
    if (count != 0) push_burst(base, count);
    tick();
    bus.start = 1'b0;
    cyc_start = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 128'(done_cnt != d0), 128'(1));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_seen", 128'(bus.out_valid), 128'(1));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data,
                 bus.out_addr, bus.busy, bus.done});
  endfunction

  initial begin
    int d0;
    int n;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h08; mem[3] = 8'h20;

    // Reset state
    tick(); tick();
    chk("reset_outs", all_outs(), 128'(0));
    rst_n = 1'b1;
    tick();

    // Single word with exact latency
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    start_req(32'h0, 1);
    wait_done(20);
    chk("single_rd_first", 128'(first_rd - cyc_start), 128'(0));
    chk("single_rd_cnt", 128'(rd_cnt), 128'(4));
    chk("single_valid_cyc", 128'(first_valid - cyc_start), 128'(5));
    chk("single_done_cyc", 128'(last_done - cyc_start), 128'(6));
    chk("single_word", 128'(last_rx_data), 128'(32'h2008_0005));
    chk("single_done_cnt", 128'(done_cnt - d0), 128'(1));

    // Zero count
    d0 = done_cnt;
    start_req(32'h0, 0);
    wait_done(5);
    chk("zero_done_cyc", 128'(last_done - cyc_start), 128'(0));
    chk("zero_rd_cnt", 128'(rd_cnt), 128'(0));
    chk("zero_busy", 128'(busy_seen), 128'(0));
    chk("zero_done_cnt", 128'(done_cnt - d0), 128'(1));

    // Burst with backpressure on word 2
    d0 = done_cnt;
    start_req(32'h10, 3);
    n = 0;
    while (words_rx < 1 && n < 40) begin tick(); n++; end
    bus.out_ready = 1'b0;
    wait_valid(40);
    repeat (5) tick();
    bus.out_ready = 1'b1;
    wait_done(60);
    chk("bp_words", 128'(words_rx), 128'(3));
    chk("bp_last_addr", 128'(last_rx_addr), 128'(32'h18));
    chk("bp_done_cnt", 128'(done_cnt - d0), 128'(1));
    chk("bp_queues", 128'(q_word.size() + q_addr.size()), 128'(0));

    // Address wrap
    start_req(32'hFFFF_FFFE, 1);
    wait_done(20);
    chk("wrap_addr", 128'(last_rx_addr), 128'(32'hFFFF_FFFE));
    chk("wrap_data", 128'(last_rx_data), 128'({mem[1], mem[0], mem[255], mem[254]}));

    // Reset during the third issue cycle
    start_req(32'h40, 2);
    tick(); tick();
    chk("rst_mid_rd_en", 128'(bus.mem_rd_en), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", all_outs(), 128'(0));
    q_addr.delete(); q_word.delete();
    prev_valid = 1'b0;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst_n = 1'b1;
    tick();
    start_req(32'h80, 1);
    wait_done(20);
    chk("rst_new_words", 128'(words_rx), 128'(1));
    chk("rst_new_data", 128'(last_rx_data), 128'(exp_word(32'h80)));

    // Start while busy is ignored
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_req(32'h20, 2);
    wait_valid(20);
    bus.base_addr = 32'h99; bus.word_count = CNT_W'(5); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    wait_done(60);
    repeat (10) tick();
    chk("busy_start_words", 128'(words_rx), 128'(2));
    chk("busy_start_done", 128'(done_cnt - d0), 128'(1));
    chk("busy_start_idle", 128'({bus.busy, bus.mem_rd_en, bus.out_valid}), 128'(0));
    chk("busy_start_queues", 128'(q_word.size() + q_addr.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
